// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: channel FSM states,
// output-mode encodings and the smallest divisor a channel will accept.
package clk_div_pkg;

   typedef enum logic [1:0] {
      StOff  = 2'd0,
      StRun  = 2'd1,
      StPend = 2'd2
   } ch_state_e;

   localparam logic ModeSquare = 1'b0;
   localparam logic ModePulse  = 1'b1;

   localparam int unsigned MinDiv = 2;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/pending divisor, load handshake and the
// square/pulse output generator. All outputs come straight from flops.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic [CNT_W-1:0] div_val,
   input  logic             load,
   output logic             load_ack,
   output logic             tick,
   output logic             clk_out
);

   localparam logic [CNT_W-1:0] One     = CNT_W'(1);
   localparam logic [CNT_W-1:0] MinDivW = CNT_W'(MinDiv);

   ch_state_e        st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] act_q, act_d;
   logic [CNT_W-1:0] pnd_q, pnd_d;
   logic             ack_q, ack_d;
   logic             tick_q, tick_d;
   logic             clk_out_q, clk_out_d;

   logic [CNT_W-1:0] div_clamped;
   logic             running;
   logic             wrap;

   assign div_clamped = (div_val < MinDivW) ? MinDivW : div_val;
   assign running     = (st_q != StOff);
   assign wrap        = running && (cnt_q == act_q - One);

   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      act_d     = act_q;
      pnd_d     = pnd_q;
      ack_d     = 1'b0;
      clk_out_d = 1'b0;

      if (!running) begin
         // While idle a load bypasses the pending slot and lands in ACT at once.
         cnt_d = '0;
         if (load) begin
            act_d = div_clamped;
            ack_d = 1'b1;
         end
         if (en) begin
            st_d = StRun;
         end
      end else if (!en) begin
         st_d  = StOff;
         cnt_d = '0;
         pnd_d = MinDivW;
      end else begin
         cnt_d     = wrap ? '0 : cnt_q + One;
         clk_out_d = (mode == ModePulse) ? wrap : (cnt_q < (act_q >> 1));
         unique case (st_q)
            StRun: begin
               if (load) begin
                  pnd_d = div_clamped;
                  st_d  = StPend;
               end
            end
            StPend: begin
               // The old pending value is consumed at wrap even if a new load arrives.
               if (wrap) begin
                  act_d = pnd_q;
                  ack_d = 1'b1;
                  if (!load) begin
                     st_d = StRun;
                  end
               end
               if (load) begin
                  pnd_d = div_clamped;
               end
            end
            default: ;
         endcase
      end

      // TICK is registered by predicting the wrap of the coming cycle.
      tick_d = (st_d != StOff) && (cnt_d == act_d - One);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= StOff;
         cnt_q     <= '0;
         act_q     <= MinDivW;
         pnd_q     <= MinDivW;
         ack_q     <= 1'b0;
         tick_q    <= 1'b0;
         clk_out_q <= 1'b0;
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         act_q     <= act_d;
         pnd_q     <= pnd_d;
         ack_q     <= ack_d;
         tick_q    <= tick_d;
         clk_out_q <= clk_out_d;
      end
   end

   assign load_ack = ack_q;
   assign tick     = tick_q;
   assign clk_out  = clk_out_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider top: reset synchroniser plus one clk_div_ch per
// channel, each fed its own slice of the packed input buses.
module clk_div_gen #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                    CLK_IN,
   input  logic                    RST_N,
   input  logic [NUM_CH-1:0]       EN,
   input  logic [NUM_CH-1:0]       MODE,
   input  logic [NUM_CH*CNT_W-1:0] DIV_VAL,
   input  logic [NUM_CH-1:0]       LOAD,
   output logic [NUM_CH-1:0]       LOAD_ACK,
   output logic [NUM_CH-1:0]       TICK,
   output logic [NUM_CH-1:0]       CLK_OUT
);

   logic [1:0] rst_sync_q;
   logic       rst_n_sync;

   // Assert asynchronously, release two clock edges after RST_N rises.
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_sync = rst_sync_q[1];

   for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
      clk_div_ch #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk      (CLK_IN),
         .rst_n    (rst_n_sync),
         .en       (EN[i]),
         .mode     (MODE[i]),
         .div_val  (DIV_VAL[i*CNT_W +: CNT_W]),
         .load     (LOAD[i]),
         .load_ack (LOAD_ACK[i]),
         .tick     (TICK[i]),
         .clk_out  (CLK_OUT[i])
      );
   end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: directed scenarios then random traffic, every cycle
// compared against a period/phase model of each channel.
module tb_clk_div_gen;

   localparam int NCH = 4;
   localparam int CW  = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    en, mode, load;
   logic [NCH*CW-1:0] div_val;
   logic [NCH-1:0]    load_ack, tick, clk_out;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: per channel, whether it runs, position in the period, period
   // length, and an optional queued next period length.
   bit             m_on  [NCH];
   int             m_pos [NCH];
   int             m_per [NCH];
   int             m_nxt [NCH];
   bit             m_has [NCH];
   logic [NCH-1:0] e_ack, e_tick, e_out;
   int             rst_hold;

   clk_div_gen #(
      .NUM_CH (NCH),
      .CNT_W  (CW)
   ) dut (
      .CLK_IN   (clk),
      .RST_N    (rst_n),
      .EN       (en),
      .MODE     (mode),
      .DIV_VAL  (div_val),
      .LOAD     (load),
      .LOAD_ACK (load_ack),
      .TICK     (tick),
      .CLK_OUT  (clk_out)
   );

   always #5 clk = ~clk;

   function automatic int clamp(logic [CW-1:0] d);
      return (int'(d) < 2) ? 2 : int'(d);
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_on[c]  = 1'b0;
         m_pos[c] = 0;
         m_per[c] = 2;
         m_nxt[c] = 2;
         m_has[c] = 1'b0;
      end
      e_ack  = '0;
      e_tick = '0;
      e_out  = '0;
   endfunction

   function automatic void model_step();
      if (!rst_n) begin
         model_reset();
         rst_hold = 2;
         return;
      end
      if (rst_hold > 0) begin
         model_reset();
         rst_hold--;
         return;
      end
      for (int c = 0; c < NCH; c++) begin
         int d        = clamp(div_val[c*CW +: CW]);
         bit was_last = m_on[c] && (m_pos[c] == m_per[c] - 1);
         e_ack[c] = 1'b0;
         if (!m_on[c]) begin
            e_out[c] = 1'b0;
            if (load[c]) begin
               m_per[c] = d;
               e_ack[c] = 1'b1;
            end
            m_on[c]  = en[c];
            m_pos[c] = 0;
            m_has[c] = 1'b0;
         end else if (!en[c]) begin
            m_on[c]  = 1'b0;
            m_pos[c] = 0;
            m_has[c] = 1'b0;
            e_out[c] = 1'b0;
         end else begin
            e_out[c] = mode[c] ? was_last : (m_pos[c] < m_per[c] / 2);
            if (was_last) begin
               m_pos[c] = 0;
               if (m_has[c]) begin
                  m_per[c] = m_nxt[c];
                  m_has[c] = 1'b0;
                  e_ack[c] = 1'b1;
               end
            end else begin
               m_pos[c]++;
            end
            if (load[c]) begin
               m_nxt[c] = d;
               m_has[c] = 1'b1;
            end
         end
         e_tick[c] = m_on[c] && (m_pos[c] == m_per[c] - 1);
      end
   endfunction

   task automatic chk(string tag, int c, logic obs, logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s ch%0d observed=%b expected=%b", tag, c, obs, exp);
   endtask

   task automatic chk_int(string tag, int c, int obs, int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s ch%0d observed=%0d expected=%0d", tag, c, obs, exp);
   endtask

   task automatic check_all();
      for (int c = 0; c < NCH; c++) begin
         chk("load_ack", c, load_ack[c], e_ack[c]);
         chk("tick", c, tick[c], e_tick[c]);
         chk("clk_out", c, clk_out[c], e_out[c]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic pulse_load(int c, int d);
      load[c]              = 1'b1;
      div_val[c*CW +: CW] = CW'(d);
      step();
      load[c] = 1'b0;
   endtask

   task automatic wait_pos(int c, int p);
      int n = 0;
      while (!m_on[c] || m_pos[c] != p) begin
         if (n == 200) begin
            chk_int("wait_pos_timeout", c, -1, p);
            return;
         end
         step();
         n++;
      end
   endtask

   // Cycles from one TICK to the next; -1 if either wait runs out.
   task automatic measure_period(int c, output int p);
      int n = 0;
      p = -1;
      do begin
         step();
         n++;
      end while (!tick[c] && n < 100);
      if (!tick[c]) return;
      n = 0;
      do begin
         step();
         n++;
      end while (!tick[c] && n < 100);
      if (tick[c]) p = n;
   endtask

   initial begin
      logic [7:0] out_seq, tick_seq;
      int         p, cnt;

      rst_n    = 1'b0;
      en       = '0;
      mode     = '0;
      load     = '0;
      div_val  = '0;
      rst_hold = 2;
      model_reset();
      step();
      step();
      rst_n = 1'b1;
      repeat (4) step();

      // Divide by 4 loaded while idle, square output.
      en[0] = 1'b1;
      pulse_load(0, 4);
      chk("ack_idle_load", 0, load_ack[0], 1'b1);
      for (int i = 0; i < 8; i++) begin
         step();
         out_seq[i]  = clk_out[0];
         tick_seq[i] = tick[0];
      end
      chk_int("div4_pattern", 0, int'(out_seq), int'(8'b0011_0011));
      chk_int("div4_ticks", 0, int'(tick_seq), int'(8'b0100_0100));

      // Odd divisor 5: 2 high per 5 in square mode, 1 per 5 in pulse mode.
      pulse_load(1, 5);
      en[1] = 1'b1;
      repeat (6) step();
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         cnt += int'(clk_out[1]);
      end
      chk_int("div5_square_high", 1, cnt, 4);
      mode[1] = 1'b1;
      cnt     = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         cnt += int'(clk_out[1]);
      end
      chk_int("div5_pulse_high", 1, cnt, 2);

      // Overwritten pending load: a single ack, then the last value wins.
      pulse_load(2, 6);
      en[2] = 1'b1;
      step();
      wait_pos(2, 2);
      pulse_load(2, 3);
      wait_pos(2, 4);
      pulse_load(2, 8);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         cnt += int'(load_ack[2]);
      end
      chk_int("single_ack", 2, cnt, 1);
      measure_period(2, p);
      chk_int("period_after_reload", 2, p, 8);

      // Divisors 0 and 1 clamp to 2.
      pulse_load(3, 5);
      en[3] = 1'b1;
      step();
      pulse_load(3, 0);
      measure_period(3, p);
      chk_int("clamp_div0", 3, p, 2);
      pulse_load(3, 4);
      measure_period(3, p);
      chk_int("restore_div4", 3, p, 4);
      pulse_load(3, 1);
      measure_period(3, p);
      chk_int("clamp_div1", 3, p, 2);

      // Disable with a load pending: output drops, no ack, old divisor kept.
      wait_pos(0, 2);
      pulse_load(0, 7);
      en[0] = 1'b0;
      step();
      chk("disable_out_low", 0, clk_out[0], 1'b0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         cnt += int'(load_ack[0]);
      end
      chk_int("disable_no_ack", 0, cnt, 0);
      en[0] = 1'b1;
      measure_period(0, p);
      chk_int("old_div_kept", 0, p, 4);

      // Asynchronous reset mid-period with mixed divisors running.
      wait_pos(2, 3);
      pulse_load(1, 9);
      rst_n = 1'b0;
      #1;
      for (int c = 0; c < NCH; c++) begin
         chk("rst_async_out", c, clk_out[c], 1'b0);
         chk("rst_async_tick", c, tick[c], 1'b0);
         chk("rst_async_ack", c, load_ack[c], 1'b0);
      end
      model_reset();
      rst_hold = 2;
      mode = '0;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();
      for (int c = 0; c < NCH; c++) begin
         measure_period(c, p);
         chk_int("post_reset_div2", c, p, 2);
      end

      // Random traffic on all channels, with occasional resets.
      for (int n = 0; n < 2500; n++) begin
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
            if ($urandom_range(0, 29) == 0) mode[c] = ~mode[c];
            load[c]              = ($urandom_range(0, 7) == 0);
            div_val[c*CW +: CW] = CW'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
         step();
         rst_n = 1'b1;
      end
      load = '0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
